// File: rtl/byte_serializer_if.sv
// Byte stream in, framed serial bitstream out, for byte_serializer.
// The master modport drives the byte source. The slave modport is the serializer itself.
interface byte_serializer_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       sof;
  logic       eof;
  logic [7:0] frames;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sof, eof, frames
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sof, eof, frames
  );
endinterface

// File: rtl/byte_serializer.sv
// Serializes each accepted byte as 8 data bits plus an even-parity bit.
// A one-entry holding register keeps back-to-back frames gap-free.
module byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               CLOCK,
  input logic               CLR,
  byte_serializer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shr_q, shr_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       par_acc_q, par_acc_d;
  logic [7:0] frames_q, frames_d;
  logic       data_bit;
  logic       accept;
  logic       load;

  assign data_bit = MSB_FIRST ? shr_q[7] : shr_q[0];
  // Accept is gated by an empty holding register, so it can never coincide with a load.
  assign accept   = bus.din_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shr_d       = shr_q;
    bitcnt_d    = bitcnt_q;
    par_acc_d   = par_acc_q;
    frames_d    = frames_q;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        shr_d     = MSB_FIRST ? {shr_q[6:0], 1'b0} : {1'b0, shr_q[7:1]};
        par_acc_d = par_acc_q ^ data_bit;
        bitcnt_d  = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = StPar;
      end
      StPar: begin
        frames_d = frames_q + 8'd1;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StData;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shr_d       = hold_q;
      hold_full_d = 1'b0;
      par_acc_d   = 1'b0;
      bitcnt_d    = 3'd0;
    end
    if (accept) begin
      hold_d      = bus.din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= StIdle;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shr_q       <= 8'h00;
      bitcnt_q    <= 3'd0;
      par_acc_q   <= 1'b0;
      frames_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shr_q       <= shr_d;
      bitcnt_q    <= bitcnt_d;
      par_acc_q   <= par_acc_d;
      frames_q    <= frames_d;
    end
  end

  assign bus.din_ready  = ~hold_full_q;
  assign bus.sout_valid = (state_q != StIdle);
  assign bus.sout       = (state_q == StData) ? data_bit : ((state_q == StPar) & par_acc_q);
  assign bus.sof        = (state_q == StData) && (bitcnt_q == 3'd0);
  assign bus.eof        = (state_q == StPar);
  assign bus.frames     = frames_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer. It drives an MSB-first and an LSB-first instance.
module tb_byte_serializer;

  logic CLOCK = 1'b0;
  logic CLR   = 1'b0;

  byte_serializer_if bus_m ();
  byte_serializer_if bus_l ();

  byte_serializer #(.MSB_FIRST(1'b1)) dut_msb (.CLOCK(CLOCK), .CLR(CLR), .bus(bus_m));
  byte_serializer #(.MSB_FIRST(1'b0)) dut_lsb (.CLOCK(CLOCK), .CLR(CLR), .bus(bus_l));

  always #5 CLOCK = ~CLOCK;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [7:0]  tx [0:7];
  bit          got [0:127];
  bit          par [0:15];
  int          got_n, par_n, hs_cnt, vcnt, first, last, eof_sof, sof_c, eof_c;
  logic [11:0] rdy_vec;
  logic [7:0]  fr_a, fr_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Packed view: {din_ready, sout, sout_valid, sof, eof, frames}
  function automatic logic [12:0] outs(input bit sel);
    if (sel) return {bus_l.din_ready, bus_l.sout, bus_l.sout_valid, bus_l.sof, bus_l.eof,
                     bus_l.frames};
    return {bus_m.din_ready, bus_m.sout, bus_m.sout_valid, bus_m.sof, bus_m.eof, bus_m.frames};
  endfunction

  function automatic logic [7:0] pack_got(input int start);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) r = {r[6:0], got[start + i]};
    return r;
  endfunction

  task automatic set_din(input bit sel, input logic [7:0] d, input bit v);
    if (sel) begin
      bus_l.din = d;
      bus_l.din_valid = v;
    end else begin
      bus_m.din = d;
      bus_m.din_valid = v;
    end
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    #1;
    @(negedge CLOCK);
    CLR = 1'b1;
  endtask

  // Offers tx[0..ntx-1] with valid/ready and records everything the serializer emits.
  task automatic run_stream(input bit sel, input int ntx, input int ncyc);
    int         idx;
    bit         hs;
    bit         prev_eof;
    logic [12:0] o;
    idx = 0; prev_eof = 1'b0;
    got_n = 0; par_n = 0; hs_cnt = 0; vcnt = 0; first = -1; last = -1; eof_sof = 0;
    sof_c = -1; eof_c = -1; rdy_vec = '0; fr_a = 8'hxx; fr_b = 8'hxx;
    set_din(sel, tx[0], ntx > 0);
    for (int c = 1; c <= ncyc; c++) begin
      o  = outs(sel);
      hs = (sel ? bus_l.din_valid : bus_m.din_valid) && o[12];
      step();
      if (hs) begin
        hs_cnt++;
        idx++;
        if (idx < ntx) set_din(sel, tx[idx], 1'b1);
        else set_din(sel, 8'h00, 1'b0);
      end
      o = outs(sel);
      if (o[10]) begin
        if (got_n < 128) got[got_n] = o[11];
        got_n++;
        vcnt++;
        if (first < 0) first = c;
        last = c;
      end
      if (o[8]) begin
        if (par_n < 16) par[par_n] = o[11];
        par_n++;
        if (eof_c < 0) eof_c = c;
      end
      if (o[9] && sof_c < 0) sof_c = c;
      if (prev_eof && o[9]) eof_sof++;
      prev_eof = o[8];
      if (c <= 12) rdy_vec = {rdy_vec[10:0], o[12]};
      if (c == 10) fr_a = o[7:0];
      if (c == 11) fr_b = o[7:0];
    end
  endtask

  initial begin
    int vseen;
    set_din(1'b0, 8'h00, 1'b0);
    set_din(1'b1, 8'h00, 1'b0);

    // Reset and idle
    #12;
    chk("reset_msb_outs", outs(1'b0), 13'h1000);
    chk("reset_lsb_outs", outs(1'b1), 13'h1000);
    @(negedge CLOCK);
    CLR = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outs", outs(1'b0), 13'h1000);
    end

    // Single byte 0xAB, MSB first: accept at edge 1
    tx[0] = 8'hAB;
    run_stream(1'b0, 1, 14);
    chk("ab_sof_cycle", sof_c, 2);
    chk("ab_eof_cycle", eof_c, 10);
    chk("ab_valid_cnt", vcnt, 9);
    chk("ab_valid_span", last - first + 1, 9);
    chk("ab_bits", pack_got(0), 8'b1010_1011);
    chk("ab_parity", par[0], 1'b1);
    chk("ab_frames_k9", fr_a, 8'd0);
    chk("ab_frames_k10", fr_b, 8'd1);
    chk("ab_idle_after", outs(1'b0), 13'h1001);

    // Back-to-back stream with valid held high
    do_reset();
    tx[0] = 8'h11; tx[1] = 8'hFF; tx[2] = 8'hAB; tx[3] = 8'hCC;
    tx[4] = 8'h99; tx[5] = 8'h88; tx[6] = 8'hE7; tx[7] = 8'hD0;
    run_stream(1'b0, 8, 80);
    chk("bb_handshakes", hs_cnt, 8);
    chk("bb_first_valid", first, 2);
    chk("bb_valid_cnt", vcnt, 72);
    chk("bb_valid_span", last - first + 1, 72);
    chk("bb_eof_to_sof", eof_sof, 7);
    chk("bb_ready_pattern", rdy_vec, 12'b0100_0000_0010);
    chk("bb_parity_seq", {par[0], par[1], par[2], par[3], par[4], par[5], par[6], par[7]},
        8'b0010_0001);
    for (int i = 0; i < 8; i++) chk("bb_frame_bits", pack_got(9 * i), tx[i]);
    chk("bb_frames", bus_m.frames, 8'd8);

    // LSB first, 0xD0
    tx[0] = 8'hD0;
    run_stream(1'b1, 1, 14);
    chk("lsb_bits", pack_got(0), 8'b0000_1011);
    chk("lsb_parity", par[0], 1'b1);
    chk("lsb_frames", bus_l.frames, 8'd1);

    // Backpressure: 0xE7 offered while 0x11 still waits in the holding register
    tx[0] = 8'h11; tx[1] = 8'hE7;
    run_stream(1'b0, 2, 24);
    chk("bp_ready_pattern", rdy_vec, 12'b0100_0000_0011);
    chk("bp_valid_cnt", vcnt, 18);
    chk("bp_valid_span", last - first + 1, 18);
    chk("bp_first_bits", pack_got(0), 8'h11);
    chk("bp_second_bits", pack_got(9), 8'hE7);
    chk("bp_parities", {par[0], par[1]}, 2'b00);
    chk("bp_frames", bus_m.frames, 8'd10);

    // Reset mid-frame: 0xCC shifting, 0x99 in the holding register
    set_din(1'b0, 8'hCC, 1'b1);
    step();
    chk("mr_ready_after_accept", bus_m.din_ready, 1'b0);
    set_din(1'b0, 8'h99, 1'b1);
    step();
    chk("mr_sof", bus_m.sof, 1'b1);
    step();
    set_din(1'b0, 8'h00, 1'b0);
    chk("mr_hold_full", bus_m.din_ready, 1'b0);
    step();
    step();
    chk("mr_mid_frame_valid", bus_m.sout_valid, 1'b1);
    chk("mr_frames_before", bus_m.frames, 8'd10);
    CLR = 1'b0;
    #1;
    chk("mr_reset_outs", outs(1'b0), 13'h1000);
    @(negedge CLOCK);
    CLR = 1'b1;
    vseen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus_m.sout_valid) vseen++;
    end
    chk("mr_nothing_emitted", vseen, 0);
    chk("mr_idle_outs", outs(1'b0), 13'h1000);
    tx[0] = 8'h88;
    run_stream(1'b0, 1, 14);
    chk("mr_new_valid_cnt", vcnt, 9);
    chk("mr_new_bits", pack_got(0), 8'h88);
    chk("mr_new_parity", par[0], 1'b0);
    chk("mr_new_frames", bus_m.frames, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
